// File: rtl/fm_audio_modulator_pkg.sv
// Shared types and constants for the FM audio modulator slice.
// Phase increments are the NCO tuning words for the 50 MHz system clock.
package fm_pkg;

  localparam int SAMPLE_W = 12;
  localparam int PHASE_W  = 32;

  typedef logic signed [SAMPLE_W-1:0] audio_sample_t;
  typedef logic        [PHASE_W-1:0]  phase_inc_t;

  localparam phase_inc_t INC_5M00 = 32'd429496730;
  localparam phase_inc_t INC_5M05 = 32'd433791697;
  localparam phase_inc_t INC_4M95 = 32'd425201762;

  // Clamp a widened sample back into the 12-bit signed range.
  function automatic audio_sample_t sat_sample(input logic signed [13:0] v);
    if (v > 14'sd2047) begin
      return 12'sh7FF;
    end else if (v < -14'sd2048) begin
      return 12'sh800;
    end else begin
      return v[11:0];
    end
  endfunction

endpackage

// File: rtl/fm_audio_modulator_if.sv
// Audio sample stream in, NCO phase increment out.
// The master side is the audio source and NCO consumer; the slave is the modulator.
interface fm_audio_modulator_if;
  import fm_pkg::*;

  logic          en_i;
  audio_sample_t s_data_i;
  logic          s_valid_i;
  logic          s_ready_o;
  phase_inc_t    phi_inc_o;
  logic          phi_valid_o;
  logic          underrun_o;

  modport master (
    output en_i, s_data_i, s_valid_i,
    input  s_ready_o, phi_inc_o, phi_valid_o, underrun_o
  );

  modport slave (
    input  en_i, s_data_i, s_valid_i,
    output s_ready_o, phi_inc_o, phi_valid_o, underrun_o
  );

endinterface

// File: rtl/fm_sample_fifo.sv
// Small synchronous sample FIFO; full/empty come from an extra pointer wrap bit.
// DEPTH must be a power of two and at least 2.
module fm_sample_fifo
  import fm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk_50M_i,
  input  logic          reset_n,
  input  logic          push,
  input  audio_sample_t push_data,
  input  logic          pop,
  output audio_sample_t head,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  audio_sample_t mem [DEPTH];

  always_ff @(posedge clk_50M_i or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_50M_i) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/fm_audio_modulator.sv
// Audio-to-phase-increment front end for the fm_5M NCO: FIFO, sample-rate divider, linear map.
// Define FM_PREEMPH_EN to insert a first-order pre-emphasis stage (one extra cycle of latency).
module fm_audio_modulator
  import fm_pkg::*;
#(
  parameter int          RATE_DIV   = 6250,
  parameter int unsigned DEV_SCALE  = 2098,
  parameter phase_inc_t  CENTER_INC = INC_5M00,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                 clk_50M_i,
  input  logic                 reset_n,
  fm_audio_modulator_if.slave  bus
);

  localparam int CNT_W = $clog2(RATE_DIV);
  localparam logic [19:0]        DEV_U   = DEV_SCALE[19:0];
  localparam logic signed [32:0] DEV_EXT = $signed({13'd0, DEV_U});

  logic [CNT_W-1:0] div_cnt;
  logic             tick;
  logic             fifo_full;
  logic             fifo_empty;
  audio_sample_t    fifo_head;

  audio_sample_t    sample_q;
  logic             sample_vld;
  logic             underrun_q;
  audio_sample_t    map_sample;
  logic             map_vld;
  phase_inc_t       prod_q;
  logic             prod_vld;
  phase_inc_t       phi_q;
  logic             phi_vld_q;

  assign tick = bus.en_i && (div_cnt == CNT_W'(RATE_DIV - 1));

  always_ff @(posedge clk_50M_i or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (!bus.en_i || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

  fm_sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_50M_i (clk_50M_i),
    .reset_n   (reset_n),
    .push      (bus.s_valid_i && !fifo_full),
    .push_data (bus.s_data_i),
    .pop       (tick && !fifo_empty),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.s_ready_o = !fifo_full;

  // An empty FIFO on a tick substitutes silence so the output falls back to the carrier.
  always_ff @(posedge clk_50M_i or negedge reset_n) begin
    if (!reset_n) begin
      sample_q   <= '0;
      sample_vld <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      sample_vld <= tick;
      underrun_q <= tick && fifo_empty;
      if (tick) sample_q <= fifo_empty ? '0 : fifo_head;
    end
  end

`ifdef FM_PREEMPH_EN
  audio_sample_t       x_prev;
  audio_sample_t       emph_q;
  logic                emph_vld;
  logic signed [13:0]  x14;
  logic signed [13:0]  p14;
  logic signed [13:0]  e14;

  assign x14 = 14'(sample_q);
  assign p14 = 14'(x_prev);
  assign e14 = x14 + ((x14 - p14) <<< 1);

  always_ff @(posedge clk_50M_i or negedge reset_n) begin
    if (!reset_n) begin
      x_prev   <= '0;
      emph_q   <= '0;
      emph_vld <= 1'b0;
    end else begin
      emph_vld <= sample_vld && bus.en_i;
      if (sample_vld) begin
        emph_q <= sat_sample(e14);
        x_prev <= sample_q;
      end
    end
  end

  assign map_sample = emph_q;
  assign map_vld    = emph_vld;
`else
  assign map_sample = sample_q;
  assign map_vld    = sample_vld;
`endif

  // The signed product never exceeds 32 bits for a 12x20 multiply, so truncation is exact.
  always_ff @(posedge clk_50M_i or negedge reset_n) begin
    if (!reset_n) begin
      prod_q   <= '0;
      prod_vld <= 1'b0;
    end else begin
      prod_vld <= map_vld && bus.en_i;
      if (map_vld) prod_q <= 32'(33'(map_sample) * DEV_EXT);
    end
  end

  always_ff @(posedge clk_50M_i or negedge reset_n) begin
    if (!reset_n) begin
      phi_q     <= CENTER_INC;
      phi_vld_q <= 1'b0;
    end else if (!bus.en_i) begin
      phi_q     <= CENTER_INC;
      phi_vld_q <= 1'b0;
    end else begin
      phi_vld_q <= prod_vld;
      if (prod_vld) phi_q <= CENTER_INC + prod_q;
    end
  end

  assign bus.phi_inc_o   = phi_q;
  assign bus.phi_valid_o = phi_vld_q;
  assign bus.underrun_o  = underrun_q;

endmodule

// File: doc/fm_audio_modulator.md
# fm_audio_modulator

- Sits directly upstream of the `fm_5M` NCO in the FM transmitter, replacing the fixed two-tone square-wave frequency select.
- Accepts signed audio samples over a valid/ready stream and buffers them in a small FIFO.
- Releases one sample per sample-rate tick and maps it linearly to a 32-bit NCO phase increment: carrier centre plus scaled deviation.
- Drives the NCO `phi_inc_i` directly.

## Interface
Parameters:
- `RATE_DIV`, 6250: system-clock cycles per audio sample (8 kHz at 50 MHz); legal range ≥ 4.
- `DEV_SCALE`, 2098: unsigned 20-bit phase-increment step per audio LSB (≈50 kHz peak deviation at 2047).
- `CENTER_INC`, 429496730: 32-bit carrier phase increment (5 MHz).
- `FIFO_DEPTH`, 4: sample FIFO depth; power of two.

Ports:
- `clk_50M_i`, input, 1: system clock, 50 MHz.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `en_i`, input, 1: modulation enable.
- `s_data_i`, input, 12: signed two's-complement audio sample.
- `s_valid_i`, input, 1: sample valid.
- `s_ready_o`, output, 1: FIFO can accept a sample.
- `phi_inc_o`, output, 32: phase increment driving the NCO.
- `phi_valid_o`, output, 1: one-cycle pulse marking a `phi_inc_o` update.
- `underrun_o`, output, 1: one-cycle pulse when a tick finds the FIFO empty.

## Operation
- **Push.** A sample is pushed when `s_valid_i && s_ready_o`. `s_ready_o = !full` is combinational from registered state, so it reads 1 during reset.
- **Rate divider.** Counts 0..RATE_DIV-1 while `en_i` is high. The tick asserts in the cycle the count equals RATE_DIV-1, and the count then wraps to 0. While `en_i` is low the counter is held at 0 and no tick occurs.
- **Tick.** If the FIFO is non-empty, pop the head sample. If it is empty, pulse `underrun_o` and use a sample of 0, which mutes to the carrier.
- **No bypass.** A push and a tick in the same cycle on an empty FIFO is an underrun. The pushed sample is stored and consumed on the next tick.
- **Full.** When full, further pushes are refused by `s_ready_o = 0`. A pop and an external push in the same cycle while full do not combine, because ready is already low.
- **Mapping.** `phi_inc_o = CENTER_INC + sext32(sample × DEV_SCALE)`.
  - The product is signed 33-bit; the sum is modulo 2^32.
  - Default parameters never wrap: extremes are 425200026 and 433791336.
- **Disable.** Dropping `en_i` causes no update pulse. `phi_inc_o` returns to `CENTER_INC` on the next cycle. FIFO contents are retained and pushes are still accepted.

## Timing
- Tick in cycle T.
- Pop and sample register in T+1.
- Multiply register in T+2.
- `phi_inc_o` update and `phi_valid_o` pulse in T+3.
- `underrun_o` pulses in T+1.
- Reset values:
  - `phi_inc_o = CENTER_INC`
  - `phi_valid_o = 0`
  - `underrun_o = 0`
  - FIFO empty, divider at 0, pipeline cleared
- Reset asserted mid-operation clears everything immediately. No in-flight update emerges after release.
- The first tick after reset release occurs at cycle RATE_DIV-1 relative to the first enabled cycle.

## Configuration
- **`FM_PREEMPH_EN` defined:** each popped sample x passes a first-order pre-emphasis stage before mapping.
  - `e = x + 2·(x − x_prev)`, computed at 14 bits and saturated to the 12-bit signed range.
  - `x_prev` is the last popped sample. It resets to 0, and underrun zero-samples update it.
  - Adds one register stage, so update latency is T+4.
- **`FM_PREEMPH_EN` not defined:** the sample maps directly with latency T+3, and no `x_prev` register exists.

## Structure
- **Package `fm_pkg`:**
  - `SAMPLE_W = 12`, `PHASE_W = 32`
  - `audio_sample_t` (signed logic [11:0]) and `phase_inc_t` (logic [31:0])
  - Constants `INC_5M00 = 429496730`, `INC_5M05 = 433791697`, `INC_4M95 = 425201762`
- **Sub-module `fm_sample_fifo`:** synchronous FIFO, depth FIFO_DEPTH, with full/empty from an extra pointer wrap bit. It uses the same clock and reset.
- The top level holds the divider, optional pre-emphasis, multiply pipeline and output register.

## Test plan
All scenarios use RATE_DIV=4 and defaults otherwise.
- **Reset.** Release reset with `en_i=1` and no samples. `phi_inc_o` stays 429496730 and `underrun_o` pulses every 4 cycles.
- **Mapping.** Push 0, 1000, -2048 (pre-emphasis off). Successive updates are 429496730, 431594730, 425200026, with `phi_valid_o` pulses 3 cycles after each tick.
- **Full FIFO.** Hold `en_i=0` and offer 5 samples. `s_ready_o` drops after the 4th push, the 5th is held off, and it is accepted one cycle after the first tick once `en_i` rises.
- **Simultaneous push and tick.** Push into an empty FIFO in the tick cycle. `underrun_o` pulses, the output is the centre, and the sample appears on the next tick.
- **Pre-emphasis.** With `FM_PREEMPH_EN` defined, `x_prev=0`, push 1000: e saturates to 2047 and `phi_inc_o` = 433791336. Then push 1000 again: `phi_inc_o` = 431594730.
- **Reset mid-pipeline.** Assert `reset_n` low at T+1 of a tick carrying 1000. After release, no `phi_valid_o` pulse occurs, the output is 429496730, and the FIFO is empty.
